// File: rtl/opcode_prefetch_decoder.sv
// opcode_prefetch_decoder
//   Byte prefetch queue plus instruction-header assembler. Bytes are fetched
//   ahead of execution into a circular queue. An assembler FSM pops them,
//   strips the 0x10/0x11 page prefix and collects any postbyte. The result is
//   one aligned header record, offered on a valid/ready handshake.
//
//   Optional feature macro: OPQ_PREFIX_CHAIN_EN. When it is defined, repeated
//   prefixes are consumed and the last one wins. When it is not defined, a
//   second prefix is taken as postbyte0.
//
// Ports
//   cpu_clk, cpu_reset_n      clock and synchronous active-low reset
//   flush, flush_addr         drop queue and record; restart fetch at flush_addr
//   mem_rd_req/addr/ack/data  single-outstanding byte read port
//   dec_valid/dec_ready       header record handshake
//   dec_pc .. dec_len         header record fields
//   q_level                   bytes currently queued
module opcode_prefetch_decoder #(
   parameter int            DEPTH    = 4,
   parameter int            AW       = 16,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                     cpu_clk,
   input  logic                     cpu_reset_n,
   input  logic                     flush,
   input  logic [AW-1:0]            flush_addr,
   output logic                     mem_rd_req,
   output logic [AW-1:0]            mem_addr,
   input  logic                     mem_rd_ack,
   input  logic [7:0]               mem_data_in,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [AW-1:0]            dec_pc,
   output logic [7:0]               dec_opcode,
   output logic [7:0]               dec_postbyte0,
   output logic                     dec_page2_valid,
   output logic                     dec_page3_valid,
   output logic [7:0]               dec_postbyte,
   output logic                     dec_has_post,
   output logic [2:0]               dec_len,
   output logic [$clog2(DEPTH):0]   q_level
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_OP, S_PAGE, S_POST, S_OUT} state_t;

   // queue
   logic [7:0]    r_q [DEPTH];
   logic [PW-1:0] r_wp, r_rp;
   logic [PW:0]   r_lvl;
   logic [AW-1:0] r_head;      // address of the byte at the queue head
   // fetch
   logic          r_req, r_disc;
   logic [AW-1:0] r_addr, r_tgt;
   // assembler
   state_t        r_state, w_nstate;
   logic [AW-1:0] r_pc;
   logic [7:0]    r_op, r_pb0, r_pb;
   logic          r_pg2, r_pg3, r_hp;
   logic [2:0]    r_len;

   logic          w_ack, w_push, w_pop, w_start, w_avail;
   logic [7:0]    w_byte;
   logic          w_is_pfx, w_need_post, w_pg_post;
   logic [PW:0]   w_lvl_nxt;
   logic [2:0]    w_len_inc;

   assign w_ack     = mem_rd_ack & r_req;
   // discarded acks (post-flush in-flight read, or an ack in the flush cycle) never reach the queue
   assign w_push    = w_ack & ~r_disc & ~flush;
   assign w_avail   = (r_lvl != '0);
   assign w_byte    = r_q[r_rp];
   assign w_lvl_nxt = r_lvl + (PW+1)'(w_push) - (PW+1)'(w_pop);
   assign w_len_inc = (r_len == 3'd7) ? 3'd7 : r_len + 3'd1;

   assign w_is_pfx    = (w_byte[7:1] == 7'b0001000);
   assign w_pg_post   = (w_byte[7:4] == 4'hA) | (w_byte[7:4] == 4'hE);
   assign w_need_post = (w_byte == 8'h1E) | (w_byte == 8'h1F) | (w_byte[7:3] == 5'b00110) |
                        (w_byte[7:4] == 4'h6) | w_pg_post;

   always_comb begin
      w_nstate = r_state;
      w_pop    = 1'b0;
      w_start  = 1'b0;
      case (r_state)
         S_OP:   if (w_avail) w_start = 1'b1;
         S_PAGE: if (w_avail) begin
            w_pop = 1'b1;
`ifdef OPQ_PREFIX_CHAIN_EN
            if (w_is_pfx) w_nstate = S_PAGE;
            else
`endif
            w_nstate = w_pg_post ? S_POST : S_OUT;
         end
         S_POST: if (w_avail) begin
            w_pop    = 1'b1;
            w_nstate = S_OUT;
         end
         S_OUT: if (dec_ready) begin
            // back-to-back: the next record starts in the transfer cycle
            if (w_avail) w_start  = 1'b1;
            else         w_nstate = S_OP;
         end
         default: w_nstate = S_OP;
      endcase
      if (w_start) begin
         w_pop    = 1'b1;
         w_nstate = w_is_pfx ? S_PAGE : (w_need_post ? S_POST : S_OUT);
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!cpu_reset_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_lvl   <= '0;
         r_head  <= RESET_PC;
         r_req   <= 1'b0;
         r_disc  <= 1'b0;
         r_addr  <= RESET_PC;
         r_tgt   <= RESET_PC;
         r_state <= S_OP;
         r_pc    <= '0;
         r_op    <= '0;
         r_pb0   <= '0;
         r_pb    <= '0;
         r_pg2   <= 1'b0;
         r_pg3   <= 1'b0;
         r_hp    <= 1'b0;
         r_len   <= '0;
      end else if (flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_lvl   <= '0;
         r_head  <= flush_addr;
         r_state <= S_OP;
         r_req   <= 1'b1;
         // an outstanding read keeps its address; its data is dropped on ack
         if (r_req && !mem_rd_ack) begin
            r_disc <= 1'b1;
            r_tgt  <= flush_addr;
         end else begin
            r_disc <= 1'b0;
            r_addr <= flush_addr;
         end
      end else begin
         if (w_ack) begin
            if (r_disc) begin
               r_addr <= r_tgt;
               r_disc <= 1'b0;
            end else begin
               r_addr <= r_addr + AW'(1);
            end
         end
         // request reflects the level it will see, so at most one read is outstanding
         if (!r_req || w_ack) r_req <= (w_lvl_nxt < FULL);
         if (w_push) begin
            r_q[r_wp] <= mem_data_in;
            r_wp      <= r_wp + PW'(1);
         end
         if (w_pop) begin
            r_rp   <= r_rp + PW'(1);
            r_head <= r_head + AW'(1);
         end
         r_lvl   <= w_lvl_nxt;
         r_state <= w_nstate;

         if (w_start) begin
            r_pc  <= r_head;
            r_op  <= w_byte;
            r_pb0 <= '0;
            r_pb  <= '0;
            r_pg2 <= (w_byte == 8'h10);
            r_pg3 <= (w_byte == 8'h11);
            r_hp  <= 1'b0;
            r_len <= 3'd1;
         end else if (w_pop) begin
            r_len <= w_len_inc;
            if (r_state == S_PAGE) begin
`ifdef OPQ_PREFIX_CHAIN_EN
               if (w_is_pfx) begin
                  r_op  <= w_byte;
                  r_pg2 <= (w_byte == 8'h10);
                  r_pg3 <= (w_byte == 8'h11);
               end else
`endif
               r_pb0 <= w_byte;
            end else begin
               r_pb <= w_byte;
               r_hp <= 1'b1;
            end
         end
      end
   end

   assign mem_rd_req      = r_req;
   assign mem_addr        = r_addr;
   assign dec_valid       = (r_state == S_OUT);
   assign dec_pc          = r_pc;
   assign dec_opcode      = r_op;
   assign dec_postbyte0   = r_pb0;
   assign dec_page2_valid = r_pg2;
   assign dec_page3_valid = r_pg3;
   assign dec_postbyte    = r_pb;
   assign dec_has_post    = r_hp;
   assign dec_len         = r_len;
   assign q_level         = r_lvl;
endmodule

// File: tb/tb_opcode_prefetch_decoder.sv
// Randomized bench for opcode_prefetch_decoder. A byte image acts as memory;
// every transferred record is compared with a parse of that image starting at
// the expected instruction address.
module tb_opcode_prefetch_decoder;
   localparam int         DEPTH = 4;
   localparam logic [2:0] QFULL = 3'd4;
   localparam logic [15:0] RPC  = 16'h0000;

   typedef struct packed {
      logic [15:0] pc;
      logic [7:0]  op;
      logic [7:0]  pb0;
      logic        pg2;
      logic        pg3;
      logic [7:0]  pb;
      logic        hp;
      logic [2:0]  len;
   } rec_t;

   logic        cpu_clk = 1'b0;
   logic        cpu_reset_n, flush, mem_rd_ack, dec_ready;
   logic [15:0] flush_addr;
   logic [7:0]  mem_data_in;
   logic        mem_rd_req, dec_valid, dec_page2_valid, dec_page3_valid, dec_has_post;
   logic [15:0] mem_addr, dec_pc;
   logic [7:0]  dec_opcode, dec_postbyte0, dec_postbyte;
   logic [2:0]  dec_len, q_level;

   opcode_prefetch_decoder #(.DEPTH(DEPTH), .AW(16), .RESET_PC(RPC)) dut (
      .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .flush(flush), .flush_addr(flush_addr),
      .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_data_in(mem_data_in),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
      .dec_postbyte0(dec_postbyte0), .dec_page2_valid(dec_page2_valid), .dec_page3_valid(dec_page3_valid),
      .dec_postbyte(dec_postbyte), .dec_has_post(dec_has_post), .dec_len(dec_len), .q_level(q_level));

   always #5 cpu_clk = ~cpu_clk;

   logic [7:0]  img [0:65535];
   int          n_vec = 0, n_err = 0, n_xfer = 0;
   logic [15:0] exp_pc = RPC;
   int          maxd = 0, wcnt = 0, rmode = 0;
   bit          hold_en = 0;
   logic [15:0] hold_addr = '0;
   bit          do_flush = 0, do_rst = 0, fl_evt = 0, rst_evt = 0;
   logic [15:0] fl_tgt = '0;
   bit          prev_pend = 0, snap_v = 0;
   logic [15:0] prev_addr = '0;
   rec_t        snap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_pfx(input logic [7:0] b);
      return b == 8'h10 || b == 8'h11;
   endfunction

   function automatic bit wants_post(input logic [7:0] b);
      int hi;
      hi = int'(b) / 16;
      return b == 8'h1E || b == 8'h1F || (b >= 8'h30 && b <= 8'h37) || hi == 6 || hi == 10 || hi == 14;
   endfunction

   // Reference: decode the header found in the image at address a.
   function automatic rec_t model(input logic [15:0] a);
      rec_t r;
      logic [15:0] p;
      logic [7:0]  b;
      int cnt, hi;
      r = '0; r.pc = a; p = a; b = img[p]; r.op = b; cnt = 1;
      if (is_pfx(b)) begin
         r.pg2 = (b == 8'h10); r.pg3 = (b == 8'h11);
         p = p + 16'd1; b = img[p];
`ifdef OPQ_PREFIX_CHAIN_EN
         for (int k = 0; k < 64 && is_pfx(b); k++) begin
            r.op = b; r.pg2 = (b == 8'h10); r.pg3 = (b == 8'h11);
            cnt++; p = p + 16'd1; b = img[p];
         end
`endif
         r.pb0 = b; cnt++;
         hi = int'(b) / 16;
         if (hi == 10 || hi == 14) begin
            p = p + 16'd1; r.pb = img[p]; r.hp = 1'b1; cnt++;
         end
      end else if (wants_post(b)) begin
         p = p + 16'd1; r.pb = img[p]; r.hp = 1'b1; cnt++;
      end
      r.len = (cnt > 7) ? 3'd7 : 3'(cnt);
      return r;
   endfunction

   function automatic rec_t dut_rec();
      rec_t r;
      r.pc = dec_pc; r.op = dec_opcode; r.pb0 = dec_postbyte0; r.pg2 = dec_page2_valid;
      r.pg3 = dec_page3_valid; r.pb = dec_postbyte; r.hp = dec_has_post; r.len = dec_len;
      return r;
   endfunction

   // Called at a falling edge: check what the last rising edge produced, then
   // drive inputs for the next rising edge and advance one cycle.
   task automatic tick();
      rec_t cur, m;
      cur = dut_rec();
      if (rst_evt) begin
         chk("rst_rec", 64'(cur), 64'd0);
         chk("rst_valid", 64'(dec_valid), 64'd0);
         chk("rst_req", 64'(mem_rd_req), 64'd0);
         chk("rst_addr", 64'(mem_addr), 64'(RPC));
         chk("rst_lvl", 64'(q_level), 64'd0);
         rst_evt = 0;
      end
      if (fl_evt) begin
         chk("flush_valid", 64'(dec_valid), 64'd0);
         chk("flush_lvl", 64'(q_level), 64'd0);
         fl_evt = 0;
      end
      if (prev_pend) begin
         chk("req_held", 64'(mem_rd_req), 64'd1);
         chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
      end
      if (snap_v) chk("dec_stable", 64'(cur), 64'(snap));
      if (q_level == QFULL) chk("full_noreq", 64'(mem_rd_req), 64'd0);
      chk("lvl_max", 64'(q_level <= QFULL), 64'd1);

      cpu_reset_n = !do_rst;
      flush       = do_flush;
      flush_addr  = fl_tgt;
      mem_rd_ack  = 1'b0;
      mem_data_in = 8'($urandom);
      if (!do_rst && mem_rd_req && !(hold_en && mem_addr == hold_addr)) begin
         if (wcnt == 0) begin
            mem_rd_ack  = 1'b1;
            mem_data_in = img[mem_addr];
            wcnt        = (maxd == 0) ? 0 : int'($urandom_range(0, maxd));
         end else wcnt--;
      end
      prev_pend = mem_rd_req && !mem_rd_ack && !do_rst;
      prev_addr = mem_addr;
      case (rmode)
         1:       dec_ready = 1'b1;
         2:       dec_ready = 1'b0;
         default: dec_ready = ($urandom_range(0, 3) != 0);
      endcase

      snap_v = 0;
      if (do_rst) begin
         exp_pc = RPC; rst_evt = 1; wcnt = 0;
      end else if (do_flush) begin
         exp_pc = fl_tgt; fl_evt = 1;
      end else if (dec_valid && dec_ready) begin
         m = model(exp_pc);
         chk("rec_pc", 64'(dec_pc), 64'(m.pc));
         chk("rec_op", 64'(dec_opcode), 64'(m.op));
         chk("rec_pb0", 64'(dec_postbyte0), 64'(m.pb0));
         chk("rec_page", 64'({dec_page2_valid, dec_page3_valid}), 64'({m.pg2, m.pg3}));
         chk("rec_post", 64'({dec_has_post, dec_postbyte}), 64'({m.hp, m.pb}));
         chk("rec_len", 64'(dec_len), 64'(m.len));
         if (exp_pc == 16'h0000) begin
            chk("tc86_op", 64'(dec_opcode), 64'h86);
            chk("tc86_len", 64'({dec_has_post, dec_len}), 64'h1);
         end
         if (exp_pc == 16'h0100)
            chk("tc10AE84", 64'({dec_opcode, dec_postbyte0, dec_page2_valid, dec_postbyte, dec_has_post, dec_len}),
                64'({8'h10, 8'hAE, 1'b1, 8'h84, 1'b1, 3'd3}));
         if (exp_pc == 16'h0103)
            chk("tc1183", 64'({dec_page3_valid, dec_postbyte0, dec_has_post, dec_len}),
                64'({1'b1, 8'h83, 1'b0, 3'd2}));
`ifdef OPQ_PREFIX_CHAIN_EN
         if (exp_pc == 16'h0110)
            chk("tc_chain", 64'({dec_page3_valid, dec_page2_valid, dec_postbyte0, dec_len}),
                64'({1'b1, 1'b0, 8'h8C, 3'd3}));
`else
         if (exp_pc == 16'h0110)
            chk("tc_2pfx", 64'({dec_page2_valid, dec_postbyte0, dec_len}), 64'({1'b1, 8'h11, 3'd2}));
`endif
         exp_pc = exp_pc + 16'(m.len);
         n_xfer++;
      end else begin
         snap_v = dec_valid;
         snap   = cur;
      end
      do_rst = 0; do_flush = 0;
      @(negedge cpu_clk);
   endtask

   initial begin
      int k;
      cpu_reset_n = 1'b0; flush = 1'b0; flush_addr = '0; mem_rd_ack = 1'b0;
      mem_data_in = '0; dec_ready = 1'b0;
      for (int i = 0; i < 65536; i++)
         img[i] = ($urandom_range(0, 7) == 0) ? (8'h10 + 8'($urandom_range(0, 1))) : 8'($urandom);
      img[0] = 8'h86; img[1] = 8'h42;
      img[16'h0100] = 8'h10; img[16'h0101] = 8'hAE; img[16'h0102] = 8'h84;
      img[16'h0103] = 8'h11; img[16'h0104] = 8'h83;
      img[16'h0110] = 8'h10; img[16'h0111] = 8'h11; img[16'h0112] = 8'h8C;

      @(negedge cpu_clk);
      do_rst = 1; tick();

      // backpressure: queue must fill and requests stop while full
      rmode = 2; maxd = 0;
      repeat (20) tick();
      chk("bp_level", 64'(q_level), 64'(QFULL));
      chk("bp_req", 64'(mem_rd_req), 64'd0);
      chk("bp_head", 64'({dec_valid, dec_pc, dec_opcode}), 64'({1'b1, 16'h0000, 8'h86}));

      // flush while the read of 0x0005 is held outstanding
      hold_en = 1; hold_addr = 16'h0005; rmode = 1;
      for (k = 0; k < 60 && !(mem_rd_req && mem_addr == 16'h0005); k++) tick();
      chk("pend5", 64'({mem_rd_req, mem_addr}), 64'({1'b1, 16'h0005}));
      rmode = 2; fl_tgt = 16'h2000; do_flush = 1; tick();
      repeat (3) begin
         chk("fl_hold_addr", 64'({mem_rd_req, mem_addr}), 64'({1'b1, 16'h0005}));
         tick();
      end
      hold_en = 0; wcnt = 0; tick();
      chk("fl_new_req", 64'({mem_rd_req, mem_addr}), 64'({1'b1, 16'h2000}));
      chk("fl_dropped", 64'(q_level), 64'd0);
      rmode = 1;
      k = n_xfer;
      for (int i = 0; i < 60 && n_xfer == k; i++) tick();
      chk("fl_first_rec", 64'(n_xfer > k), 64'd1);

      // prefixed headers at 0x0100 and 0x0110
      fl_tgt = 16'h0100; do_flush = 1; maxd = 2; tick();
      for (int i = 0; i < 200 && exp_pc != 16'h0105; i++) tick();
      chk("reach_0105", 64'(exp_pc), 64'h0105);
      fl_tgt = 16'h0110; do_flush = 1; tick();
      for (int i = 0; i < 200 && exp_pc != 16'h0113; i++) tick();
      chk("reach_0113", 64'(exp_pc), 64'h0113);

      // reset while waiting for the postbyte of 10 AE 84
      fl_tgt = 16'h0100; do_flush = 1; maxd = 0; hold_en = 1; hold_addr = 16'h0102; tick();
      for (k = 0; k < 60 && !(mem_rd_req && mem_addr == 16'h0102); k++) tick();
      repeat (3) tick();
      chk("spost_wait", 64'({mem_rd_req, mem_addr, dec_valid, q_level}), 64'({1'b1, 16'h0102, 1'b0, 3'd0}));
      do_rst = 1; tick();
      hold_en = 0;

      // random traffic with flushes, ack delays and occasional resets
      rmode = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 400 == 0) maxd = int'($urandom_range(0, 3));
         if ($urandom_range(0, 63) == 0) begin
            do_flush = 1;
            case ($urandom_range(0, 3))
               0:       fl_tgt = 16'h0100;
               1:       fl_tgt = 16'hFFFD;
               default: fl_tgt = 16'($urandom);
            endcase
         end else if ($urandom_range(0, 999) == 0) do_rst = 1;
         tick();
      end
      tick();
      chk("traffic", 64'(n_xfer > 500), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
